// File: rtl/ctrl_fsm.sv
// Multi-cycle control sequencer: decodes one opcode per fetch handshake and walks DECODE/EXEC/MEM/MDU/WB/TRAP.
// Define CTRL_MDU_EN to route OP/OP-32 with funct7=0000001 through the MUL/DIV handshake; otherwise it traps as illegal.
module ctrl_fsm #(
  parameter int RV64      = 1,
  parameter int TIMEOUT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [6:0] op_code,
  input  logic [6:0] funct7,
  output logic       alu_src,
  output logic [1:0] alu_op,
  output logic       mem2reg,
  output logic       word_op,
  output logic       mem_req,
  output logic       mem_we,
  input  logic       mem_ack,
  output logic       mdu_start,
  input  logic       mdu_done,
  output logic       reg_w,
  output logic       busy,
  output logic       illegal,
  output logic       bus_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_EXEC, S_MEM, S_MDU, S_WB, S_TRAP
  } state_t;

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;
  localparam logic [6:0] F7_MDU      = 7'b0000001;

  state_t state, state_n;

  logic [6:0] op_q, f7_q;
  logic       is_load, is_store, is_mdu, ill_q, berr_q;
  logic [TIMEOUT_W-1:0] cnt, cnt_inc;

  logic       dec_ok, dec_src, dec_m2r, dec_word, dec_load, dec_store, dec_mdu, f7_is_mdu;
  logic [1:0] dec_aop;

  // Instruction fields are plain data captured on the fetch handshake.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && instr_valid) begin
      op_q <= op_code;
      f7_q <= funct7;
    end
  end

  assign f7_is_mdu = (f7_q == F7_MDU);
  assign cnt_inc   = cnt + TIMEOUT_W'(1);

  always_comb begin
    dec_ok    = 1'b1;
    dec_src   = 1'b0;
    dec_aop   = 2'b00;
    dec_m2r   = 1'b0;
    dec_word  = 1'b0;
    dec_load  = 1'b0;
    dec_store = 1'b0;
    dec_mdu   = 1'b0;
    case (op_q)
      OPC_LOAD: begin
        dec_src  = 1'b1;
        dec_m2r  = 1'b1;
        dec_load = 1'b1;
      end
      OPC_STORE: begin
        dec_src   = 1'b1;
        dec_store = 1'b1;
      end
      OPC_OPIMM: begin
        dec_src = 1'b1;
        dec_aop = 2'b11;
      end
      OPC_OPIMM32: begin
        if (RV64 != 0) begin
          dec_src  = 1'b1;
          dec_aop  = 2'b11;
          dec_word = 1'b1;
        end else begin
          dec_ok = 1'b0;
        end
      end
      OPC_OP, OPC_OP32: begin
        dec_aop  = 2'b10;
        dec_word = (op_q == OPC_OP32);
        if (op_q == OPC_OP32 && RV64 == 0) dec_ok = 1'b0;
`ifdef CTRL_MDU_EN
        dec_mdu = f7_is_mdu;
`else
        if (f7_is_mdu) dec_ok = 1'b0;
`endif
      end
      default: dec_ok = 1'b0;
    endcase
    // An illegal instruction leaves every datapath control inactive.
    if (!dec_ok) begin
      dec_src   = 1'b0;
      dec_aop   = 2'b00;
      dec_m2r   = 1'b0;
      dec_word  = 1'b0;
      dec_load  = 1'b0;
      dec_store = 1'b0;
      dec_mdu   = 1'b0;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (instr_valid) state_n = S_DECODE;
      S_DECODE: state_n = dec_ok ? S_EXEC : S_TRAP;
      S_EXEC: begin
        if (is_load || is_store) state_n = S_MEM;
        else if (is_mdu)         state_n = S_MDU;
        else                     state_n = S_WB;
      end
      // An ack in the same cycle as the timeout completes the access.
      S_MEM: begin
        if (mem_ack)             state_n = is_load ? S_WB : S_IDLE;
        else if (cnt_inc == '1)  state_n = S_TRAP;
      end
`ifdef CTRL_MDU_EN
      S_MDU:    if (mdu_done) state_n = S_WB;
`else
      S_MDU:    state_n = S_IDLE;
`endif
      S_WB:     state_n = S_IDLE;
      S_TRAP:   state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      alu_src  <= 1'b0;
      alu_op   <= 2'b00;
      mem2reg  <= 1'b0;
      word_op  <= 1'b0;
      is_load  <= 1'b0;
      is_store <= 1'b0;
      is_mdu   <= 1'b0;
      ill_q    <= 1'b0;
      berr_q   <= 1'b0;
      cnt      <= '0;
    end else begin
      state <= state_n;
      case (state)
        S_DECODE: begin
          alu_src  <= dec_src;
          alu_op   <= dec_aop;
          mem2reg  <= dec_m2r;
          word_op  <= dec_word;
          is_load  <= dec_load;
          is_store <= dec_store;
          is_mdu   <= dec_mdu;
          ill_q    <= !dec_ok;
          berr_q   <= 1'b0;
        end
        S_EXEC: cnt <= '0;
        S_MEM: begin
          if (!mem_ack) begin
            cnt <= cnt_inc;
            if (cnt_inc == '1) berr_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign instr_ready = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign mem_req     = (state == S_MEM);
  assign mem_we      = (state == S_MEM) && is_store;
  assign reg_w       = (state == S_WB);
  assign illegal     = (state == S_TRAP) && ill_q;
  assign bus_err     = (state == S_TRAP) && berr_q;

`ifdef CTRL_MDU_EN
  assign mdu_start = (state == S_EXEC) && is_mdu;
`else
  logic unused_mdu_done;
  assign unused_mdu_done = mdu_done;
  assign mdu_start       = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_fsm.sv
// Directed bench for ctrl_fsm: latency, memory handshake, timeout, traps, MDU path and async reset.
module tb_ctrl_fsm;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       instr_valid = 1'b0;
  logic [6:0] op_code = '0;
  logic [6:0] funct7 = '0;
  logic       mem_ack = 1'b0;
  logic       mdu_done = 1'b0;

  logic       instr_ready, alu_src, mem2reg, word_op, mem_req, mem_we, mdu_start, reg_w, busy, illegal, bus_err;
  logic [1:0] alu_op;
  logic       instr_ready_b, alu_src_b, mem2reg_b, word_op_b, mem_req_b, mem_we_b, mdu_start_b, reg_w_b, busy_b, illegal_b, bus_err_b;
  logic [1:0] alu_op_b;

  int nchecks = 0;
  int nerrors = 0;

  always #5 clk = ~clk;

  ctrl_fsm #(.RV64(1), .TIMEOUT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .op_code(op_code), .funct7(funct7), .alu_src(alu_src), .alu_op(alu_op),
    .mem2reg(mem2reg), .word_op(word_op), .mem_req(mem_req), .mem_we(mem_we),
    .mem_ack(mem_ack), .mdu_start(mdu_start), .mdu_done(mdu_done), .reg_w(reg_w),
    .busy(busy), .illegal(illegal), .bus_err(bus_err)
  );

  ctrl_fsm #(.RV64(0), .TIMEOUT_W(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready_b),
    .op_code(op_code), .funct7(funct7), .alu_src(alu_src_b), .alu_op(alu_op_b),
    .mem2reg(mem2reg_b), .word_op(word_op_b), .mem_req(mem_req_b), .mem_we(mem_we_b),
    .mem_ack(mem_ack), .mdu_start(mdu_start_b), .mdu_done(mdu_done), .reg_w(reg_w_b),
    .busy(busy_b), .illegal(illegal_b), .bus_err(bus_err_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    instr_valid = 1'b0;
    mem_ack = 1'b0;
    mdu_done = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Transfer in the current (IDLE) cycle 0; returns in cycle 1.
  task automatic send(input logic [6:0] op, input logic [6:0] f7);
    instr_valid = 1'b1;
    op_code = op;
    funct7 = f7;
    step();
    instr_valid = 1'b0;
  endtask

  // Load run: ackat = index of MEM cycle that sees mem_ack (0 = never).
  task automatic run_load(input int ackat, output int nreq, output int nw, output int nbus,
                          output int nm2r, output int wcyc, output int bcyc);
    nreq = 0; nw = 0; nbus = 0; nm2r = 0; wcyc = -1; bcyc = -1;
    send(7'b0000011, 7'b0);
    step();
    for (int c = 3; c < 30; c++) begin
      step();
      if (mem_req) nreq++;
      if (mem_req && mem2reg) nm2r++;
      if (reg_w) begin nw++; wcyc = c; end
      if (bus_err) begin nbus++; bcyc = c; end
      mem_ack = (ackat > 0) && mem_req && (nreq == ackat);
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] outs;
    #3;
    outs = {instr_ready, busy, alu_src, alu_op, mem2reg, word_op, mem_req, mem_we, reg_w, illegal, bus_err};
    nchecks++;
    if (outs !== 12'b1000_0000_0000) begin
      nerrors++;
      $display("FAIL reset_outputs: got %b expected %b", outs, 12'b1000_0000_0000);
    end
    nchecks++;
    if (mdu_start !== 1'b0) begin
      nerrors++;
      $display("FAIL reset_mdu_start: got %b expected 0", mdu_start);
    end
    apply_reset();
  endtask

  task automatic test_alu();
    send(7'b0110011, 7'b0);
    nchecks++;
    if ({busy, instr_ready} !== 2'b10) begin
      nerrors++;
      $display("FAIL alu_c1_busy_ready: got %b expected 10", {busy, instr_ready});
    end
    step();
    nchecks++;
    if ({alu_src, alu_op, reg_w, word_op} !== 5'b0_10_0_0) begin
      nerrors++;
      $display("FAIL alu_c2_controls: got %b expected 01000", {alu_src, alu_op, reg_w, word_op});
    end
    step();
    nchecks++;
    if (reg_w !== 1'b1) begin
      nerrors++;
      $display("FAIL alu_c3_reg_w: got %b expected 1", reg_w);
    end
    step();
    nchecks++;
    if ({instr_ready, reg_w} !== 2'b10) begin
      nerrors++;
      $display("FAIL alu_c4_ready: got %b expected 10", {instr_ready, reg_w});
    end
  endtask

  task automatic test_load();
    int nreq, nw, nbus, nm2r, wcyc, bcyc;
    run_load(4, nreq, nw, nbus, nm2r, wcyc, bcyc);
    nchecks++;
    if (nreq !== 4 || nm2r !== 4) begin
      nerrors++;
      $display("FAIL load_mem_req_cycles: got req=%0d m2r=%0d expected 4 4", nreq, nm2r);
    end
    nchecks++;
    if (nw !== 1 || wcyc !== 7) begin
      nerrors++;
      $display("FAIL load_reg_w: got count=%0d cycle=%0d expected 1 at 7", nw, wcyc);
    end
    nchecks++;
    if (nbus !== 0) begin
      nerrors++;
      $display("FAIL load_bus_err: got %0d expected 0", nbus);
    end
  endtask

  task automatic test_store();
    int nw = 0;
    send(7'b0100011, 7'b0);
    if (reg_w) nw++;
    step();
    if (reg_w) nw++;
    nchecks++;
    if ({alu_src, alu_op, mem_req} !== 4'b1_00_0) begin
      nerrors++;
      $display("FAIL store_c2_controls: got %b expected 1000", {alu_src, alu_op, mem_req});
    end
    step();
    nchecks++;
    if ({mem_req, mem_we} !== 2'b11) begin
      nerrors++;
      $display("FAIL store_c3_req_we: got %b expected 11", {mem_req, mem_we});
    end
    mem_ack = 1'b1;
    if (reg_w) nw++;
    step();
    mem_ack = 1'b0;
    if (reg_w) nw++;
    nchecks++;
    if ({mem_req, mem_we, instr_ready} !== 3'b001) begin
      nerrors++;
      $display("FAIL store_c4_idle: got %b expected 001", {mem_req, mem_we, instr_ready});
    end
    step();
    if (reg_w) nw++;
    nchecks++;
    if (nw !== 0) begin
      nerrors++;
      $display("FAIL store_reg_w: got %0d pulses expected 0", nw);
    end
  endtask

  task automatic test_timeout();
    int nreq, nw, nbus, nm2r, wcyc, bcyc;
    run_load(0, nreq, nw, nbus, nm2r, wcyc, bcyc);
    nchecks++;
    if (nreq !== 15 || nbus !== 1 || bcyc !== 18) begin
      nerrors++;
      $display("FAIL timeout_bus_err: got req=%0d bus=%0d at %0d expected 15 1 at 18", nreq, nbus, bcyc);
    end
    nchecks++;
    if (nw !== 0) begin
      nerrors++;
      $display("FAIL timeout_reg_w: got %0d expected 0", nw);
    end
    run_load(15, nreq, nw, nbus, nm2r, wcyc, bcyc);
    nchecks++;
    if (nreq !== 15 || nbus !== 0 || nw !== 1 || wcyc !== 18) begin
      nerrors++;
      $display("FAIL timeout_late_ack: got req=%0d bus=%0d w=%0d at %0d expected 15 0 1 at 18",
               nreq, nbus, nw, wcyc);
    end
  endtask

  task automatic test_illegal();
    send(7'b1111111, 7'b0);
    nchecks++;
    if (illegal !== 1'b0) begin
      nerrors++;
      $display("FAIL illegal_c1: got %b expected 0", illegal);
    end
    step();
    nchecks++;
    if ({illegal, mem_req, reg_w, bus_err} !== 4'b1000) begin
      nerrors++;
      $display("FAIL illegal_c2: got %b expected 1000", {illegal, mem_req, reg_w, bus_err});
    end
    step();
    nchecks++;
    if ({illegal, instr_ready, reg_w} !== 3'b010) begin
      nerrors++;
      $display("FAIL illegal_c3: got %b expected 010", {illegal, instr_ready, reg_w});
    end
  endtask

  task automatic test_rv32();
    apply_reset();
    send(7'b0111011, 7'b0);
    step();
    nchecks++;
    if (illegal_b !== 1'b1) begin
      nerrors++;
      $display("FAIL rv32_op32_illegal: got %b expected 1", illegal_b);
    end
    nchecks++;
    if ({illegal, word_op, alu_op} !== 4'b0_1_10) begin
      nerrors++;
      $display("FAIL rv64_op32_decode: got %b expected 0110", {illegal, word_op, alu_op});
    end
    step();
    nchecks++;
    if ({reg_w, reg_w_b, instr_ready_b} !== 3'b101) begin
      nerrors++;
      $display("FAIL rv64_rv32_c3: got %b expected 101", {reg_w, reg_w_b, instr_ready_b});
    end
    step();
  endtask

  task automatic test_mdu();
    send(7'b0110011, 7'b0000001);
    step();
`ifdef CTRL_MDU_EN
    nchecks++;
    if ({mdu_start, alu_op, illegal} !== 4'b1_10_0) begin
      nerrors++;
      $display("FAIL mdu_c2_start: got %b expected 1100", {mdu_start, alu_op, illegal});
    end
    for (int c = 3; c < 6; c++) begin
      step();
      nchecks++;
      if ({mdu_start, reg_w, busy} !== 3'b001) begin
        nerrors++;
        $display("FAIL mdu_wait_c%0d: got %b expected 001", c, {mdu_start, reg_w, busy});
      end
    end
    mdu_done = 1'b1;
    step();
    mdu_done = 1'b0;
    nchecks++;
    if (reg_w !== 1'b1) begin
      nerrors++;
      $display("FAIL mdu_reg_w: got %b expected 1", reg_w);
    end
    step();
`else
    nchecks++;
    if ({illegal, mdu_start, reg_w} !== 3'b100) begin
      nerrors++;
      $display("FAIL mdu_disabled_illegal: got %b expected 100", {illegal, mdu_start, reg_w});
    end
    step();
`endif
    nchecks++;
    if (instr_ready !== 1'b1) begin
      nerrors++;
      $display("FAIL mdu_back_idle: got %b expected 1", instr_ready);
    end
  endtask

  task automatic test_back_to_back();
    instr_valid = 1'b1;
    op_code = 7'b0010011;
    funct7 = 7'b0;
    step();
    step();
    nchecks++;
    if ({alu_src, alu_op, instr_ready} !== 4'b1_11_0) begin
      nerrors++;
      $display("FAIL b2b_c2_opimm: got %b expected 1110", {alu_src, alu_op, instr_ready});
    end
    step();
    step();
    nchecks++;
    if (instr_ready !== 1'b1) begin
      nerrors++;
      $display("FAIL b2b_c4_ready: got %b expected 1", instr_ready);
    end
    step();
    instr_valid = 1'b0;
    nchecks++;
    if (busy !== 1'b1) begin
      nerrors++;
      $display("FAIL b2b_c5_second_accept: got %b expected 1", busy);
    end
    for (int c = 0; c < 4; c++) step();
  endtask

  task automatic test_async_reset();
    send(7'b0100011, 7'b0);
    step();
    step();
    nchecks++;
    if (mem_req !== 1'b1) begin
      nerrors++;
      $display("FAIL areset_in_mem: got %b expected 1", mem_req);
    end
    #1 rst_n = 1'b0;
    #1;
    nchecks++;
    if ({mem_req, mem_we, busy, alu_src} !== 4'b0000) begin
      nerrors++;
      $display("FAIL areset_immediate: got %b expected 0000", {mem_req, mem_we, busy, alu_src});
    end
    step();
    rst_n = 1'b1;
    mem_ack = 1'b1;
    step();
    step();
    mem_ack = 1'b0;
    nchecks++;
    if ({mem_req, reg_w, busy, instr_ready} !== 4'b0001) begin
      nerrors++;
      $display("FAIL areset_late_ack: got %b expected 0001", {mem_req, reg_w, busy, instr_ready});
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_timeout();
    test_illegal();
    test_mdu();
    test_back_to_back();
    test_async_reset();
    test_rv32();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
